hazard_md: RTL and testbench
============================

Name: hazard_md

Overview:
- Parametrised next-generation hazard unit for the 5-stage RISC-V pipeline.
- Keeps M/W operand forwarding, load-use stall and branch/jump flush.
- Adds tracking of one outstanding multi-cycle mul/div operation: latency counter, destination capture, RAW/WAW/structural stalls, and a dedicated writeback strobe with forwarding from it.
- Sits beside the datapath and drives the F/D/E pipeline-register enables and flushes, the E-stage operand muxes, and the mul/div register-file write port.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, $clog2(NREGS), register-index width (derived).
- MD_LAT, 4, cycles from mul/div issue in E to its writeback; legal range 1..15.
- CW, $clog2(MD_LAT+1), latency counter width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Rs1D, Rs2D, RdD  in  AW  D-stage source and destination indices
- RegWriteD  in  1  D-stage instruction writes RdD
- MdStartD  in  1  D-stage instruction is mul/div
- Rs1E, Rs2E, RdE  in  AW  E-stage indices
- ResultSrcE_zero  in  1  E-stage instruction is a load
- MdStartE  in  1  E-stage instruction is mul/div; the decoder clears its RegWrite, so it never writes through M/W
- PCSrcE  in  1  taken branch or jump in E
- RdM  in  AW  M-stage destination; RegWriteM  in  1  M-stage write enable
- RdW  in  AW  W-stage destination; RegWriteW  in  1  W-stage write enable
- StallF, StallD  out  1  hold PC and the D register
- FlushD, FlushE  out  1  clear the D and E registers
- ForwardAE, ForwardBE  out  2  00 register file, 01 W, 10 M, 11 mul/div result
- MdBusy  out  1  a mul/div operation is outstanding
- MdWbEn  out  1  mul/div result written this cycle through the second write port
- MdWbRd  out  AW  destination of that write

Behaviour:
- State: cnt[CW], pendRd[AW]. Reset (async): cnt=0, pendRd=0, so MdBusy=0, MdWbEn=0, MdWbRd=0.
- All other outputs are combinational. With idle inputs after reset they are all 0.
- Reset asserted mid-operation aborts the pending op; no writeback strobe is issued afterwards.
- MdBusy = (cnt!=0). MdWbEn = (cnt==1). MdWbRd = pendRd. Define late = MdBusy & (cnt>1).
- Issue: MdStartE high at a clock edge loads cnt=MD_LAT and pendRd=RdE. Otherwise, while cnt!=0, cnt decrements.
- Issue and final writeback in the same cycle (cnt==1 & MdStartE): the load wins. The old op still writes back this cycle.
- Forwarding for source A (source B is identical with Rs2E). Priority, and Rs1E==0 always yields 00:
  - 10 if RegWriteM & RdM==Rs1E
  - else 11 if MdWbEn & pendRd==Rs1E
  - else 01 if RegWriteW & RdW==Rs1E
  - else 00
- lwStall = ResultSrcE_zero & RdE!=0 & (Rs1D==RdE | Rs2D==RdE). Unlike the previous unit, x0 never stalls.
- mdRaw = (MdStartE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE)) | (late & pendRd!=0 & (Rs1D==pendRd | Rs2D==pendRd)).
- At cnt==1 no RAW stall applies. The register file is write-through, so the D read sees the mul/div result.
- mdWaw = RegWriteD & RdD!=0 & ((MdStartE & RdD==RdE) | (late & RdD==pendRd)).
- mdStruct = MdStartD & (late | (MdStartE & MD_LAT>1)).
- stall = lwStall | mdRaw | mdWaw | mdStruct.
- StallF = StallD = stall & ~PCSrcE. A taken branch kills the stalled D instruction, so the front end is not held.
- FlushD = PCSrcE. FlushE = stall | PCSrcE.
- A flushed or killed D instruction never issues, so the scoreboard is unaffected by PCSrcE.
- Only one mul/div is outstanding at a time; mdStruct guarantees this.

Decomposition:
- Package hazard_io holds:
  - forward-select enum typedef fwd_sel_t (FWD_RF=00, FWD_W=01, FWD_M=10, FWD_MD=11)
  - function match_nz(a, b), true when a==b and a!=0
- Sub-module md_scoreboard: cnt/pendRd registers, producing MdBusy, late, MdWbEn and MdWbRd.
- hazard_md holds the comparators, forwarding muxes and stall/flush logic.

Test Plan:
- Reset mid-op: MdStartE with RdE=5 (MD_LAT=4), assert reset two cycles later -> MdBusy=0 immediately, MdWbEn never rises.
- Forwarding priority: Rs1E=7, RegWriteM with RdM=7, RegWriteW with RdW=7 -> ForwardAE=10. Drop RegWriteM -> 01. Rs1E=0 with all matching -> 00.
- Load-use: ResultSrcE_zero, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1. Same with RdE=0 -> no stall.
- Mul/div RAW: issue with RdE=9, then Rs1D=9 in D:
  - stall for 4 cycles (issue cycle, cnt=4, cnt=3, cnt=2); released at cnt==1 with MdWbEn=1, MdWbRd=9
  - an E instruction with Rs1E=9 in that cycle gets ForwardAE=11
- WAW and structural: while cnt=3 with pendRd=9, RegWriteD & RdD=9 -> stall; MdStartD -> stall until cnt==1, then issue reloads cnt=4.
- Branch during stall: mdRaw active and PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1, cnt keeps decrementing.

Source files
------------

// File: rtl/hazard_md_pkg.sv
// Shared types and helpers for the mul/div-aware hazard unit.
// Forward-select encoding and a non-zero index comparator.
package hazard_io;

    // E-stage operand mux select
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10,
        FWD_MD = 2'b11
    } fwd_sel_t;

    // Widest register index the helper accepts
    localparam int IDXW = 16;

    // Index equality that never matches x0
    function automatic logic match_nz(
        input logic [IDXW-1:0] a,
        input logic [IDXW-1:0] b
    );
        return (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/hazard_md_scoreboard.sv
// Tracks the single outstanding mul/div op: latency and destination.
// A new issue always reloads, even on the old op's final cycle.
module md_scoreboard #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4,
    parameter int CW     = $clog2(MD_LAT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mdStartE,
    input  logic [AW-1:0] rdE,
    output logic          mdBusy,
    output logic          late,
    output logic          mdWbEn,
    output logic [AW-1:0] mdWbRd
);

    logic [CW-1:0] cnt;
    logic [AW-1:0] pendRd;

    // Latency counter and destination capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            pendRd <= '0;
        end else if (mdStartE) begin
            cnt    <= CW'(MD_LAT);
            pendRd <= rdE;
        end else if (cnt != '0) begin
            cnt    <= cnt - CW'(1);
        end
    end

    assign mdBusy = (cnt != '0);
    assign late   = (cnt > CW'(1));
    assign mdWbEn = (cnt == CW'(1));
    assign mdWbRd = pendRd;

endmodule

// File: rtl/hazard_md.sv
// Hazard unit: M/W/mul-div forwarding, load-use and mul/div stalls,
// branch flush. Drives F/D/E enables and the mul/div write port.
module hazard_md #(
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int MD_LAT = 4,
    parameter int CW     = $clog2(MD_LAT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] Rs1D,
    input  logic [AW-1:0] Rs2D,
    input  logic [AW-1:0] RdD,
    input  logic          RegWriteD,
    input  logic          MdStartD,
    input  logic [AW-1:0] Rs1E,
    input  logic [AW-1:0] Rs2E,
    input  logic [AW-1:0] RdE,
    input  logic          ResultSrcE_zero,
    input  logic          MdStartE,
    input  logic          PCSrcE,
    input  logic [AW-1:0] RdM,
    input  logic          RegWriteM,
    input  logic [AW-1:0] RdW,
    input  logic          RegWriteW,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushD,
    output logic          FlushE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          MdBusy,
    output logic          MdWbEn,
    output logic [AW-1:0] MdWbRd
);

    import hazard_io::*;

    // A second issue is only a conflict if ops overlap
    localparam logic MULTI = (MD_LAT > 1);

    function automatic logic hit(
        input logic [AW-1:0] a,
        input logic [AW-1:0] b
    );
        return match_nz(IDXW'(a), IDXW'(b));
    endfunction

    logic late;

    md_scoreboard #(
        .AW     (AW),
        .MD_LAT (MD_LAT),
        .CW     (CW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .mdStartE (MdStartE),
        .rdE      (RdE),
        .mdBusy   (MdBusy),
        .late     (late),
        .mdWbEn   (MdWbEn),
        .mdWbRd   (MdWbRd)
    );

    fwd_sel_t fwdA;
    fwd_sel_t fwdB;

    // Source A select: M beats mul/div beats W
    always_comb begin
        fwdA = FWD_RF;
        if (RegWriteM && hit(RdM, Rs1E))
            fwdA = FWD_M;
        else if (MdWbEn && hit(MdWbRd, Rs1E))
            fwdA = FWD_MD;
        else if (RegWriteW && hit(RdW, Rs1E))
            fwdA = FWD_W;
    end

    // Source B select, same priority
    always_comb begin
        fwdB = FWD_RF;
        if (RegWriteM && hit(RdM, Rs2E))
            fwdB = FWD_M;
        else if (MdWbEn && hit(MdWbRd, Rs2E))
            fwdB = FWD_MD;
        else if (RegWriteW && hit(RdW, Rs2E))
            fwdB = FWD_W;
    end

    assign ForwardAE = fwdA;
    assign ForwardBE = fwdB;

    logic srcHitE;
    logic srcHitP;
    logic lwStall;
    logic mdRaw;
    logic mdWaw;
    logic mdStruct;
    logic stall;

    // Stall sources; at cnt==1 the write-through RF covers RAW
    always_comb begin
        srcHitE  = hit(Rs1D, RdE) | hit(Rs2D, RdE);
        srcHitP  = hit(Rs1D, MdWbRd) | hit(Rs2D, MdWbRd);
        lwStall  = ResultSrcE_zero & srcHitE;
        mdRaw    = (MdStartE & srcHitE) | (late & srcHitP);
        mdWaw    = RegWriteD
                 & ((MdStartE & hit(RdD, RdE))
                 | (late & hit(RdD, MdWbRd)));
        mdStruct = MdStartD & (late | (MdStartE & MULTI));
        stall    = lwStall | mdRaw | mdWaw | mdStruct;
    end

    // A taken branch kills the stalled D op, so do not hold F/D
    always_comb begin
        StallF = stall & ~PCSrcE;
        StallD = stall & ~PCSrcE;
        FlushD = PCSrcE;
        FlushE = stall | PCSrcE;
    end

endmodule

// File: tb/tb_hazard_md.sv
// Directed bench for hazard_md (MD_LAT=4, 32 regs).
// Expected output vectors are queued per step and popped at sample time.
module tb_hazard_md;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Rs1D, Rs2D, RdD;
    logic          RegWriteD, MdStartD;
    logic [AW-1:0] Rs1E, Rs2E, RdE;
    logic          ResultSrcE_zero, MdStartE, PCSrcE;
    logic [AW-1:0] RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic          StallF, StallD, FlushD, FlushE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          MdBusy, MdWbEn;
    logic [AW-1:0] MdWbRd;

    typedef struct {
        string       tag;
        logic [14:0] val;
    } exp_t;

    exp_t q[$];
    int   nChk  = 0;
    int   nPass = 0;

    hazard_md dut (
        .clk             (clk),
        .reset           (reset),
        .Rs1D            (Rs1D),
        .Rs2D            (Rs2D),
        .RdD             (RdD),
        .RegWriteD       (RegWriteD),
        .MdStartD        (MdStartD),
        .Rs1E            (Rs1E),
        .Rs2E            (Rs2E),
        .RdE             (RdE),
        .ResultSrcE_zero (ResultSrcE_zero),
        .MdStartE        (MdStartE),
        .PCSrcE          (PCSrcE),
        .RdM             (RdM),
        .RegWriteM       (RegWriteM),
        .RdW             (RdW),
        .RegWriteW       (RegWriteW),
        .StallF          (StallF),
        .StallD          (StallD),
        .FlushD          (FlushD),
        .FlushE          (FlushE),
        .ForwardAE       (ForwardAE),
        .ForwardBE       (ForwardBE),
        .MdBusy          (MdBusy),
        .MdWbEn          (MdWbEn),
        .MdWbRd          (MdWbRd)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ex(
        input logic sf, input logic sd,
        input logic fd, input logic fe,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic busy, input logic wb,
        input logic [4:0] rd
    );
        return {sf, sd, fd, fe, fa, fb, busy, wb, rd};
    endfunction

    task automatic idle();
        Rs1D = '0; Rs2D = '0; RdD = '0;
        RegWriteD = 1'b0; MdStartD = 1'b0;
        Rs1E = '0; Rs2E = '0; RdE = '0;
        ResultSrcE_zero = 1'b0; MdStartE = 1'b0; PCSrcE = 1'b0;
        RdM = '0; RegWriteM = 1'b0;
        RdW = '0; RegWriteW = 1'b0;
    endtask

    // Queue expectation, sample on negedge, then move to next cycle
    task automatic stepChk(input string tag, input logic [14:0] e);
        exp_t x;
        logic [14:0] obs;
        q.push_back('{tag: tag, val: e});
        @(negedge clk);
        x   = q.pop_front();
        obs = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               MdBusy, MdWbEn, MdWbRd};
        nChk++;
        assert (obs === x.val) nPass++;
        else $error("FAIL %s obs=%b expected=%b", x.tag, obs, x.val);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        stepChk("reset", ex(0,0,0,0,2'b00,2'b00,0,0,5'd0));
        reset = 1'b0;
        stepChk("idle", ex(0,0,0,0,2'b00,2'b00,0,0,5'd0));

        // forwarding priority
        idle(); Rs1E = 7; RegWriteM = 1; RdM = 7; RegWriteW = 1; RdW = 7;
        stepChk("fwdM", ex(0,0,0,0,2'b10,2'b00,0,0,5'd0));
        idle(); Rs1E = 7; RdM = 7; RegWriteW = 1; RdW = 7;
        stepChk("fwdW", ex(0,0,0,0,2'b01,2'b00,0,0,5'd0));
        idle(); RegWriteM = 1; RegWriteW = 1;
        stepChk("fwdX0", ex(0,0,0,0,2'b00,2'b00,0,0,5'd0));
        idle(); Rs2E = 7; RegWriteM = 1; RdM = 7; RegWriteW = 1; RdW = 7;
        stepChk("fwdBM", ex(0,0,0,0,2'b00,2'b10,0,0,5'd0));

        // load-use
        idle(); ResultSrcE_zero = 1; RdE = 3; Rs2D = 3;
        stepChk("lwStall", ex(1,1,0,1,2'b00,2'b00,0,0,5'd0));
        idle(); ResultSrcE_zero = 1;
        stepChk("lwX0", ex(0,0,0,0,2'b00,2'b00,0,0,5'd0));

        // mul/div RAW: issue then held consumer
        idle(); MdStartE = 1; RdE = 9; Rs1D = 9;
        stepChk("rawIss", ex(1,1,0,1,2'b00,2'b00,0,0,5'd0));
        idle(); Rs1D = 9;
        stepChk("raw4", ex(1,1,0,1,2'b00,2'b00,1,0,5'd9));
        idle(); Rs1D = 9;
        stepChk("raw3", ex(1,1,0,1,2'b00,2'b00,1,0,5'd9));
        idle(); Rs1D = 9;
        stepChk("raw2", ex(1,1,0,1,2'b00,2'b00,1,0,5'd9));
        idle(); Rs1D = 9; Rs1E = 9; RegWriteW = 1; RdW = 9;
        stepChk("raw1Fwd", ex(0,0,0,0,2'b11,2'b00,1,1,5'd9));
        idle();
        stepChk("rawDone", ex(0,0,0,0,2'b00,2'b00,0,0,5'd9));

        // structural and WAW, then reload on final cycle
        idle(); MdStartE = 1; RdE = 9;
        stepChk("iss2", ex(0,0,0,0,2'b00,2'b00,0,0,5'd9));
        idle(); MdStartD = 1;
        stepChk("struct4", ex(1,1,0,1,2'b00,2'b00,1,0,5'd9));
        idle(); RegWriteD = 1; RdD = 9;
        stepChk("waw3", ex(1,1,0,1,2'b00,2'b00,1,0,5'd9));
        idle(); RegWriteD = 1; RdD = 5;
        stepChk("noWaw2", ex(0,0,0,0,2'b00,2'b00,1,0,5'd9));
        idle(); MdStartE = 1; RdE = 12;
        stepChk("reload1", ex(0,0,0,0,2'b00,2'b00,1,1,5'd9));
        idle();
        stepChk("reload4", ex(0,0,0,0,2'b00,2'b00,1,0,5'd12));

        // branch during mul/div RAW stall
        idle(); Rs1D = 12; PCSrcE = 1;
        stepChk("brStall", ex(0,0,1,1,2'b00,2'b00,1,0,5'd12));
        idle();
        stepChk("br2", ex(0,0,0,0,2'b00,2'b00,1,0,5'd12));
        idle();
        stepChk("br1", ex(0,0,0,0,2'b00,2'b00,1,1,5'd12));
        idle();
        stepChk("br0", ex(0,0,0,0,2'b00,2'b00,0,0,5'd12));

        // reset mid-op
        idle(); MdStartE = 1; RdE = 5;
        stepChk("rIss", ex(0,0,0,0,2'b00,2'b00,0,0,5'd12));
        idle();
        stepChk("r4", ex(0,0,0,0,2'b00,2'b00,1,0,5'd5));
        stepChk("r3", ex(0,0,0,0,2'b00,2'b00,1,0,5'd5));
        reset = 1'b1;
        stepChk("rMid", ex(0,0,0,0,2'b00,2'b00,0,0,5'd0));
        reset = 1'b0;
        for (int i = 0; i < 6; i++)
            stepChk("rNoWb", ex(0,0,0,0,2'b00,2'b00,0,0,5'd0));

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
